dcpu16_arb: RTL
===============

Name: dcpu16_arb

Overview:
- Two-master, one-slave bus arbiter that shares a single memory port between the instruction/writeback bus (FBUS, fs_*) and the operand bus (ABUS, ab_*) of the dcpu16 core.
- Sits between the core's fs_*/ab_* ports and a unified memory.
- Grants one master at a time with a registered grant FSM, forwards the granted transaction to mem_*, and routes the slave acknowledge back to the granted master only.

Parameters:
- PRIO, 0, tie policy: 0 = round-robin on simultaneous requests; 1 = ABUS always wins ties.
- TMO, 255, timeout in cycles spent in a grant state without mem_ack (used only with DCPU16_ARB_TMO_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- fs_stb  in  1  FBUS request strobe
- fs_wre  in  1  FBUS write enable
- fs_adr  in  16  FBUS address
- fs_dto  in  16  FBUS write data
- fs_ack  out  1  FBUS acknowledge
- fs_dti  out  16  FBUS read data
- ab_stb  in  1  ABUS request strobe
- ab_wre  in  1  ABUS write enable
- ab_adr  in  16  ABUS address
- ab_dto  in  16  ABUS write data
- ab_ack  out  1  ABUS acknowledge
- ab_dti  out  16  ABUS read data
- mem_stb  out  1  memory strobe
- mem_wre  out  1  memory write enable
- mem_adr  out  16  memory address
- mem_dto  out  16  memory write data
- mem_dti  in  16  memory read data
- mem_ack  in  1  memory acknowledge
- tmo  out  1  sticky timeout flag

Behaviour:
- Bus protocol:
  - Classic strobe/ack.
  - A master holds stb, wre, adr and dto stable until it sees its ack.
  - An ack cycle completes exactly one transfer.
- FSM states: IDLE, GFS (FBUS granted), GAB (ABUS granted). State is registered.
- lst register: records the last-granted master (0 = FS, 1 = AB).
- Reset (rst low, asynchronous):
  - state = IDLE, lst = 0, tmo = 0, timeout counter = 0.
  - Therefore mem_stb = 0, mem_wre = 0, mem_adr = 0, mem_dto = 0, fs_ack = 0, ab_ack = 0.
- IDLE:
  - mem_* outputs are driven to 0.
  - At the clock edge: only fs_stb -> GFS; only ab_stb -> GAB.
  - Both requesting, PRIO=0 -> grant the master != lst.
  - Both requesting, PRIO=1 -> GAB.
  - Neither -> stay in IDLE.
- GFS / GAB:
  - mem_stb/wre/adr/dto are combinational copies of the granted master's signals.
  - mem_stb = granted stb.
  - The non-granted master sees ack = 0.
- Ack routing:
  - granted ack = mem_ack & mem_stb, combinational, same cycle as mem_ack.
  - fs_dti = ab_dti = mem_dti, combinational broadcast; only the acked master samples it.
- Entering a grant state: lst is updated at that edge to the granted master.
- On the ack edge:
  - If the other master's stb is high -> go directly to its grant state (no idle cycle).
  - Otherwise -> IDLE.
  - The acked master's stb in the ack cycle is treated as belonging to the finished transfer, so the same master re-requesting always passes through IDLE.
- Abort: if the granted master drops stb before ack -> mem_stb falls the same cycle and the FSM returns to IDLE at the next edge.
- Spurious ack: mem_ack while in IDLE is ignored; no master ack is generated.
- Latency:
  - Request at cycle N in IDLE -> mem_stb high in cycle N+1.
  - A zero-wait slave acks in N+1 -> master ack in N+1.
  - Minimum 2 cycles per transfer from idle.
  - Alternating back-to-back requests: 1 cycle per transfer.
- Mid-transfer reset: the asynchronous reset drops mem_stb immediately; the in-flight transfer is discarded.

Optional Feature:
- Macro: DCPU16_ARB_TMO_EN.
- Enabled:
  - An 8-bit-or-wider counter (width = clog2(TMO+1)) clears on entry to a grant state and increments each grant cycle without mem_ack.
  - When it reaches TMO: the arbiter asserts the granted master's ack for one cycle with its dti forced to 16'hFFFF, deasserts mem_stb in that cycle, sets tmo = 1, and leaves the grant state as on a normal ack.
  - tmo clears only on reset.
- Disabled: no counter is built, tmo is tied to 0, and a grant state can persist indefinitely.

Test Plan:
- Reset, then fs_stb=1, fs_adr=16'h0010, read, slave acks the same cycle with mem_dti=16'h1234 -> mem_stb rises 1 cycle after the request, fs_ack=1 with fs_dti=16'h1234, ab_ack stays 0, FSM returns to IDLE.
- fs_stb and ab_stb rise together from reset, PRIO=0 -> ABUS served first (lst=0). At the ab ack, fs_stb is still high -> next cycle mem_adr=fs_adr, with no IDLE cycle between.
- PRIO=1, both masters requesting continuously for 4 transfers -> ABUS wins every tie from IDLE; FBUS is served only via the direct handoff after each ABUS ack.
- ab write (ab_wre=1, ab_adr=16'hFFFE, ab_dto=16'hBEEF) with the slave inserting 3 wait states -> mem_wre=1, mem_dto=16'hBEEF held for 4 cycles; exactly one ab_ack pulse.
- The granted FBUS drops fs_stb after 2 wait cycles (abort) -> mem_stb falls the same cycle, FSM goes to IDLE at the next edge, no fs_ack.
- With DCPU16_ARB_TMO_EN and TMO=4, the slave never acks -> fs_ack pulses after 4 grant cycles with fs_dti=16'hFFFF, and tmo=1 until rst is asserted low.

Source files
------------

// File: rtl/dcpu16_arb_if.sv
// dcpu16_arb_if: one strobe/ack memory-bus channel (request fields from the master, ack/read data back).
// The master modport belongs to whoever issues the transfer, the slave modport to whoever answers it.
interface dcpu16_arb_if;
    logic        stb;
    logic        wre;
    logic [15:0] adr;
    logic [15:0] dto;
    logic        ack;
    logic [15:0] dti;

    modport master (output stb, output wre, output adr, output dto, input  ack, input  dti);
    modport slave  (input  stb, input  wre, input  adr, input  dto, output ack, output dti);
endinterface

// File: rtl/dcpu16_arb.sv
// dcpu16_arb: shares one memory port between the dcpu16 FBUS (fs) and ABUS (ab) with a registered grant FSM.
// Define DCPU16_ARB_TMO_EN to build the stalled-grant watchdog (TMO cycles) and the sticky tmo flag.
module dcpu16_arb #(
    parameter int PRIO = 0,
    parameter int TMO  = 255
) (
    input  logic         clk,
    input  logic         rst,
    dcpu16_arb_if.slave  fs,
    dcpu16_arb_if.slave  ab,
    dcpu16_arb_if.master mem,
    output logic         tmo
);

    typedef enum logic [1:0] {IDLE, GFS, GAB} state_t;

    state_t state;
    state_t state_nx;
    logic   lst;
    logic   tmo_hit;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        mem.stb  = 1'b0;
        mem.wre  = 1'b0;
        mem.adr  = '0;
        mem.dto  = '0;
        fs.ack   = 1'b0;
        ab.ack   = 1'b0;
        fs.dti   = mem.dti;
        ab.dti   = mem.dti;
        state_nx = state;
        case (state)
            IDLE: begin
                if (fs.stb && ab.stb) begin
                    state_nx = (PRIO != 0 || !lst) ? GAB : GFS;
                end else if (fs.stb) begin
                    state_nx = GFS;
                end else if (ab.stb) begin
                    state_nx = GAB;
                end
            end
            GFS: begin
                mem.stb = fs.stb & ~tmo_hit;
                mem.wre = fs.wre;
                mem.adr = fs.adr;
                mem.dto = fs.dto;
                fs.ack  = (mem.ack & mem.stb) | tmo_hit;
                if (tmo_hit) fs.dti = 16'hFFFF;
                // The acked master's own stb is ignored here, so a re-request goes through IDLE.
                if (fs.ack)       state_nx = ab.stb ? GAB : IDLE;
                else if (!fs.stb) state_nx = IDLE;
            end
            GAB: begin
                mem.stb = ab.stb & ~tmo_hit;
                mem.wre = ab.wre;
                mem.adr = ab.adr;
                mem.dto = ab.dto;
                ab.ack  = (mem.ack & mem.stb) | tmo_hit;
                if (tmo_hit) ab.dti = 16'hFFFF;
                if (ab.ack)       state_nx = fs.stb ? GFS : IDLE;
                else if (!ab.stb) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            lst   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != IDLE) lst <= (state_nx == GAB);
        end
    end

`ifdef DCPU16_ARB_TMO_EN
    localparam int CW = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;

    logic [CW-1:0] cnt;
    logic          tmo_q;
    logic          granted_stb;

    assign granted_stb = (state == GFS) ? fs.stb : ab.stb;
    // A master that already dropped stb is aborting, so the watchdog stays out of its way.
    assign tmo_hit     = (state != IDLE) && granted_stb && (cnt == CW'(TMO));
    assign tmo         = tmo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (state_nx != IDLE && state_nx != state) cnt <= '0;
            else if (state != IDLE && !mem.ack)        cnt <= cnt + 1'b1;
            if (tmo_hit) tmo_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo     = 1'b0;
`endif

endmodule
